// File: rtl/shift_pkg.sv
// Shared encodings for the multicycle shift unit: operation codes and FSM states.
package shift_pkg;

   typedef enum logic [1:0] {
      OP_SRL = 2'b00,
      OP_SRA = 2'b01,
      OP_SLL = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_e;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// Single-position shift step: moves the operand one bit according to the operation.
import shift_pkg::*;

module shift_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d,
   input  op_e              op,
   output logic [WIDTH-1:0] q
);

   // One-bit move; ROR feeds bit 0 back in at the top
   always_comb begin
      q = d;
      case (op)
         OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
         OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
         OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
         OP_ROR:  q = {d[0], d[WIDTH-1:1]};
         default: q = d;
      endcase
   end

endmodule : shift_step

// File: rtl/shift_right_seq.sv
// Multicycle shifter (SRL/SRA/SLL/ROR), one bit position per clock, start/done handshake.
import shift_pkg::*;

module shift_right_seq #(
   parameter  int WIDTH   = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   data_out
);

   state_e             r_state;
   op_e                r_op;
   logic [SHAMT_W-1:0] r_count;
   logic [WIDTH-1:0]   r_data;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   w_step;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .d  (r_data),
      .op (r_op),
      .q  (w_step)
   );

   // FSM, count and data register; busy/done registered from the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_op    <= OP_SRL;
         r_count <= {SHAMT_W{1'b0}};
         r_data  <= {WIDTH{1'b0}};
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_data  <= data_in;
                  r_count <= shamt;
                  r_op    <= op_e'(op);
                  if (shamt == {SHAMT_W{1'b0}}) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_SHIFT;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                  end
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            S_SHIFT: begin
               r_data  <= w_step;
               r_count <= r_count - SHAMT_W'(1);
               if (r_count == SHAMT_W'(1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_SHIFT;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            S_DONE: begin
               // Start is ignored here; the earliest new accept is the following IDLE cycle
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign data_out = r_data;

endmodule : shift_right_seq
